// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int          WIDTH       = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_INCR     = 32'(INSTR_BYTES);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched {pc, instruction} pairs; flush empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM and queues {pc, instr} for decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise misalign and halt fetch until reset.
module fetch_unit #(
    parameter int               WIDTH    = fetch_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_pkg::RESET_PC),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_instruction,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             misalign
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   pc;
    logic               halted;
    logic               redirect_take;
    logic               push;
    logic               pop;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [2*WIDTH-1:0] head_data;
    logic [WIDTH-1:0]   aligned_target;

    assign aligned_target = {redirect_target[WIDTH-1:2], 2'b00};
    assign redirect_take  = redirect_valid && !halted;
    assign pop            = instr_valid && instr_ready;
    assign push           = !redirect_valid && !halted && (!q_full || pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_take && (redirect_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    // The trap flag doubles as the halt: both are set together and only reset clears them.
    assign halted   = misalign_q;
    assign misalign = misalign_q;
`else
    assign halted   = 1'b0;
    assign misalign = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_take) begin
            pc <= aligned_target;
        end else if (push) begin
            pc <= pc + WIDTH'(PC_INCR);
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_take),
        .push_data ({pc, rom_instruction}),
        .head_data (head_data),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign rom_address = pc;
    assign instr_valid = !q_empty;
    assign instr_pc    = head_data[2*WIDTH-1:WIDTH];
    assign instr       = head_data[WIDTH-1:0];

    logic unused_ok;
    assign unused_ok = ^{q_count, redirect_target[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr}, a negedge monitor checks pops.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] rom_address;
    logic [31:0] rom_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    fetch_entry_t exp_q[$];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .misalign        (misalign)
    );

    // ROM word i holds 0x1000_0000 + i.
    assign rom_instruction = 32'h1000_0000 + (rom_address >> 2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] word);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = word;
        exp_q.push_back(e);
    endtask

    // A handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected no instruction at %0t",
                         instr_pc, instr, $time);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.instr);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset state and streaming from PC 0.
        tick();
        tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_rom_address", rom_address, 32'h0);
        check("rst_misalign", 32'(misalign), 32'd0);
        for (int i = 0; i < 8; i++) expect_entry(32'(i * 4), 32'h1000_0000 + 32'(i));
        rst = 1'b0;
        check("valid_before_first_edge", 32'(instr_valid), 32'd0);
        tick();
        check("valid_after_first_fetch", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 7; i++) tick();

        // Back-pressure: reset again with decode stalled.
        rst         = 1'b1;
        instr_ready = 1'b0;
        exp_q.delete();
        tick();
        check("rst2_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("stall_pc_holds", rom_address, 32'h8);
        check("stall_head_pc", instr_pc, 32'h0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        expect_entry(32'h0, 32'h1000_0000);
        expect_entry(32'h4, 32'h1000_0001);
        expect_entry(32'h8, 32'h1000_0002);
        instr_ready = 1'b1;
        tick();
        tick();
        check("pre_redirect_head", instr_pc, 32'h8);

        // Redirect with a same-cycle pop of 0x8; 0xC must be discarded.
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble_valid", 32'(instr_valid), 32'd0);
        check("redir_rom_address", rom_address, 32'h40);
        expect_entry(32'h40, 32'h1000_0010);
        expect_entry(32'h44, 32'h1000_0011);
        expect_entry(32'h48, 32'h1000_0012);
        tick();
        check("redir_valid_n2", 32'(instr_valid), 32'd1);
        tick();
        tick();

        // PC wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        expect_entry(32'hFFFF_FFF8, 32'h4FFF_FFFE);
        expect_entry(32'hFFFF_FFFC, 32'h4FFF_FFFF);
        expect_entry(32'h0000_0000, 32'h1000_0000);
        expect_entry(32'h0000_0004, 32'h1000_0001);
        for (int i = 0; i < 4; i++) tick();

        // Misaligned redirect.
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("misalign_rom_address", rom_address, 32'h40);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_set", 32'(misalign), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("halted_ignores_redirect", rom_address, 32'h40);
        check("halted_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        check("halted_valid_later", 32'(instr_valid), 32'd0);
        check("misalign_sticky", 32'(misalign), 32'd1);
`else
        check("misalign_clear", 32'(misalign), 32'd0);
        expect_entry(32'h40, 32'h1000_0010);
        expect_entry(32'h44, 32'h1000_0011);
        tick();
        check("misalign_fetch_pc", instr_pc, 32'h40);
        tick();
        tick();
`endif

        // Reset mid-stream with a pending redirect.
        rst             = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        exp_q.delete();
        tick();
        check("rst3_valid", 32'(instr_valid), 32'd0);
        check("rst3_rom_address", rom_address, 32'h0);
        check("rst3_misalign", 32'(misalign), 32'd0);
        check("rst3_instr", instr, 32'h0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        expect_entry(32'h0, 32'h1000_0000);
        expect_entry(32'h4, 32'h1000_0001);
        tick();
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
